abc_ext_n: RTL

Parametrised N-channel acquisition controller. It starts a conversion on N converters with one shared `soc`, waits for every `eoc`, and registers the minimum or maximum of the enabled channel samples. It then hands the result to a consumer over a `dav_`/`rfd` handshake. It is the generalised successor of the fixed three-channel, 8-bit minimum controller, and adds:
- channel masking
- a run-time min/max mode
- an empty-mask rule
- an optional winning-index output

---
 rtl/abc_pkg.sv | 16 +
 rtl/abc_ext_tree.sv | 58 +++++
 rtl/abc_ext_n.sv | 124 ++++++++++++
 3 files changed

// File: rtl/abc_pkg.sv
// abc_pkg: shared FSM states, mode constants and index-width helper for abc_ext_n
package abc_pkg;
    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_CONV  = 2'd1,
        S_OUT   = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic MODE_MIN = 1'b0;
    localparam logic MODE_MAX = 1'b1;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/abc_ext_tree.sv
// abc_ext_tree: combinational min/max select over the masked channels of x
// Ports: x (N*W samples), mask (latched channel enables), mode (MODE_MIN/MODE_MAX),
//        ext (extremum, or the empty-mask sentinel), idx (winner, only with ABC_INDEX_EN)
module abc_ext_tree
    import abc_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic [N*W-1:0]        x,
    input  logic [N-1:0]          mask,
    input  logic                  mode,
    output logic [W-1:0]          ext
`ifdef ABC_INDEX_EN
    ,
    output logic [idx_w(N)-1:0]   idx
`endif
);
    localparam int IW = idx_w(N);

    logic [W-1:0] best;
    logic [W-1:0] xi;
    logic [W:0]   diff;
    logic         have;
    logic         better;
`ifdef ABC_INDEX_EN
    logic [IW-1:0] best_i;
`endif

    // The sentinel doubles as the empty-mask result; "have" stops it from
    // beating a real sample equal to it, so ties always go to the lowest index.
    always_comb begin
        best   = (mode == MODE_MIN) ? '1 : '0;
        have   = 1'b0;
        xi     = '0;
        diff   = '0;
        better = 1'b0;
`ifdef ABC_INDEX_EN
        best_i = '0;
`endif
        for (int i = 0; i < N; i++) begin
            xi     = x[i*W +: W];
            // borrow out of a-b (diff[W]) is set exactly when a < b
            diff   = (mode == MODE_MIN) ? {1'b0, xi} - {1'b0, best} : {1'b0, best} - {1'b0, xi};
            better = mask[i] && (!have || diff[W]);
            best   = better ? xi : best;
`ifdef ABC_INDEX_EN
            best_i = better ? IW'(i) : best_i;
`endif
            have   = have | mask[i];
        end
    end

    assign ext = best;
`ifdef ABC_INDEX_EN
    assign idx = best_i;
`endif
endmodule

// File: rtl/abc_ext_n.sv
// abc_ext_n: N-channel acquisition controller registering the min/max of masked samples
// Ports: clock, reset (async, active-high), eoc[N], x[N*W], mask[N], mode, rfd (in);
//        soc, dav_ (active-low), res[W], idx (only with ABC_INDEX_EN) (out)
// Build option: define ABC_INDEX_EN to add the winning-channel index output.
module abc_ext_n
    import abc_pkg::*;
#(
    parameter int N = 3,
    parameter int W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          eoc,
    input  logic [N*W-1:0]        x,
    input  logic [N-1:0]          mask,
    input  logic                  mode,
    input  logic                  rfd,
    output logic                  soc,
    output logic                  dav_,
    output logic [W-1:0]          res
`ifdef ABC_INDEX_EN
    ,
    output logic [idx_w(N)-1:0]   idx
`endif
);
    localparam int IW = idx_w(N);

    state_t        state_q, state_d;
    logic          soc_q, soc_d;
    logic          dav_q, dav_d;
    logic [W-1:0]  res_q, res_d;
    logic [N-1:0]  mask_q, mask_d;
    logic          mode_q, mode_d;
    logic [W-1:0]  ext;
`ifdef ABC_INDEX_EN
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ext_idx;
`endif

    abc_ext_tree #(.N(N), .W(W)) u_tree (
        .x    (x),
        .mask (mask_q),
        .mode (mode_q),
        .ext  (ext)
`ifdef ABC_INDEX_EN
        ,
        .idx  (ext_idx)
`endif
    );

    // The tree sees live x but latched mask/mode, so only the S_CONV exit
    // edge decides which samples land in res.
    always_comb begin
        state_d = state_q;
        soc_d   = soc_q;
        dav_d   = dav_q;
        res_d   = res_q;
        mask_d  = mask_q;
        mode_d  = mode_q;
`ifdef ABC_INDEX_EN
        idx_d   = idx_q;
`endif
        case (state_q)
            S_START: begin
                soc_d = 1'b1;
                if (eoc == '0) begin
                    state_d = S_CONV;
                    mask_d  = mask;
                    mode_d  = mode;
                end
            end
            S_CONV: begin
                soc_d = 1'b0;
                if (&eoc) begin
                    state_d = S_OUT;
                    res_d   = ext;
`ifdef ABC_INDEX_EN
                    idx_d   = ext_idx;
`endif
                    dav_d   = 1'b0;
                end
            end
            S_OUT: begin
                if (!rfd) begin
                    state_d = S_ACK;
                    dav_d   = 1'b1;
                end
            end
            S_ACK: state_d = rfd ? S_START : S_ACK;
            default: state_d = S_START;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_START;
            soc_q   <= 1'b0;
            dav_q   <= 1'b1;
            res_q   <= '0;
            mask_q  <= '0;
            mode_q  <= MODE_MIN;
`ifdef ABC_INDEX_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            soc_q   <= soc_d;
            dav_q   <= dav_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
            mode_q  <= mode_d;
`ifdef ABC_INDEX_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign soc  = soc_q;
    assign dav_ = dav_q;
    assign res  = res_q;
`ifdef ABC_INDEX_EN
    assign idx  = idx_q;
`endif
endmodule
